// File: rtl/seq_detector_param_if.sv
// Bundle of the serial-bit, configuration and status signals of the
// parametrised pattern detector. The master side is the bit source and
// configuration owner; the slave side is the detector itself.
interface seq_detector_param_if #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_bit;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic             cnt_clr;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             armed;
   logic             cfg_err;

   modport master (
      output in_valid,
      output in_bit,
      output cfg_load,
      output cfg_pattern,
      output cfg_len,
      output cfg_overlap,
      output cnt_clr,
      input  match,
      input  match_cnt,
      input  armed,
      input  cfg_err
   );

   modport slave (
      input  in_valid,
      input  in_bit,
      input  cfg_load,
      input  cfg_pattern,
      input  cfg_len,
      input  cfg_overlap,
      input  cnt_clr,
      output match,
      output match_cnt,
      output armed,
      output cfg_err
   );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector.
// A pattern of run-time length (2..PAT_W) is loaded with a one-cycle strobe;
// qualified input bits are shifted into a history register and compared,
// newest bit against pattern bit 0, against the active pattern bits only.
// Produces a registered one-cycle match pulse, a saturating match counter,
// an armed flag and a sticky configuration error flag.
module seq_detector_param #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_detector_param_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Mask selecting the low 'len' bits; bits above the active length are
   // don't-care for the comparison.
   function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
      logic [PAT_W-1:0] m;
      m = '0;
      for (int i = 0; i < PAT_W; i++) begin
         if (i < int'(len)) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   state_t           state_r;
   logic [PAT_W-2:0] hist_r;
   logic [LEN_W-1:0] fill_r;
   logic [PAT_W-1:0] pat_r;
   logic [LEN_W-1:0] len_r;
   logic             ovl_r;
   logic             match_r;
   logic [CNT_W-1:0] cnt_r;
   logic             armed_r;
   logic             err_r;

   logic [PAT_W-1:0] cand_s;
   logic [PAT_W-1:0] mism_s;
   logic [LEN_W:0]   fill_inc_s;
   logic [LEN_W-1:0] fill_sat_s;
   logic             hit_s;
   logic             cnt_sat_s;
   logic             cfg_legal_s;

   // Candidate window, match decision and saturating helpers
   always_comb begin
      cand_s      = {hist_r, bus.in_bit};
      mism_s      = (cand_s ^ pat_r) & len_mask(len_r);
      // one extra bit so fill+1 cannot wrap when PAT_W sits at the top of LEN_W
      fill_inc_s  = {1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1};
      fill_sat_s  = fill_r;
      hit_s       = 1'b0;
      cnt_sat_s   = (cnt_r == {CNT_W{1'b1}});
      cfg_legal_s = (bus.cfg_len >= LEN_W'(2)) && (bus.cfg_len <= LEN_W'(PAT_W));

      if (fill_inc_s > (LEN_W+1)'(PAT_W)) begin
         fill_sat_s = LEN_W'(PAT_W);
      end else begin
         fill_sat_s = fill_inc_s[LEN_W-1:0];
      end

      // a load in the same cycle drops the incoming bit, so it cannot hit
      if ((state_r == ST_RUN) && bus.in_valid && !bus.cfg_load &&
          (fill_inc_s >= {1'b0, len_r}) && (mism_s == '0)) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
   end

   // Match counter: clear has priority over a coincident hit, no wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (bus.cnt_clr) begin
         cnt_r <= '0;
      end else if (hit_s && !cnt_sat_s) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Detector FSM: configuration latching, history shift and registered flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         hist_r  <= '0;
         fill_r  <= '0;
         pat_r   <= '0;
         len_r   <= '0;
         ovl_r   <= 1'b0;
         match_r <= 1'b0;
         armed_r <= 1'b0;
         err_r   <= 1'b0;
      end else if (bus.cfg_load) begin
         // every load restarts detection from an empty history
         hist_r  <= '0;
         fill_r  <= '0;
         match_r <= 1'b0;
         if (cfg_legal_s) begin
            state_r <= ST_RUN;
            pat_r   <= bus.cfg_pattern;
            len_r   <= bus.cfg_len;
            ovl_r   <= bus.cfg_overlap;
            armed_r <= 1'b1;
            err_r   <= 1'b0;
         end else begin
            // illegal length: drop the old configuration as well
            state_r <= ST_IDLE;
            pat_r   <= '0;
            len_r   <= '0;
            ovl_r   <= 1'b0;
            armed_r <= 1'b0;
            err_r   <= 1'b1;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               match_r <= 1'b0;
               armed_r <= 1'b0;
            end
            ST_RUN: begin
               armed_r <= 1'b1;
               if (bus.in_valid) begin
                  hist_r  <= cand_s[PAT_W-2:0];
                  match_r <= hit_s;
                  // non-overlapping mode: the next match needs len fresh bits
                  if (hit_s && !ovl_r) begin
                     fill_r <= '0;
                  end else begin
                     fill_r <= fill_sat_s;
                  end
               end else begin
                  match_r <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               match_r <= 1'b0;
               armed_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.match     = match_r;
   assign bus.match_cnt = cnt_r;
   assign bus.armed     = armed_r;
   assign bus.cfg_err   = err_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: directed table, hand-written multi-cycle
// sequences (gaps, saturation, async reset) and randomized stimulus checked
// against a queue-based reference model of the matching rules.
module tb_seq_detector_param;

   logic clk;
   logic rst_n;

   int n_checks;
   int n_fail;

   seq_detector_param_if #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) bus_a ();
   seq_detector_param_if #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) bus_b ();

   seq_detector_param #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   seq_detector_param #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic       b;
      logic       ld;
      logic [7:0] pat;
      logic [3:0] len;
      logic       ovl;
      logic       clr;
      logic       em;
      logic [7:0] ec;
      logic       ea;
      logic       ee;
   } vec_t;

   vec_t tbl[$];

   // reference model state (DUT A)
   bit         q[$];
   int         m_since;
   bit         m_armed;
   bit         m_err;
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl;
   bit         m_match;
   int         m_cnt;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic b, input logic ld,
                               input logic [7:0] pat, input logic [3:0] len,
                               input logic ovl, input logic clr, input logic em,
                               input logic [7:0] ec, input logic ea, input logic ee);
      vec_t t;
      t.v = v; t.b = b; t.ld = ld; t.pat = pat; t.len = len; t.ovl = ovl;
      t.clr = clr; t.em = em; t.ec = ec; t.ea = ea; t.ee = ee;
      return t;
   endfunction

   task automatic model_reset();
      q.delete();
      m_since = 0; m_armed = 0; m_err = 0; m_pat = '0; m_len = 0;
      m_ovl = 0; m_match = 0; m_cnt = 0;
   endtask

   // Matching rules: accepted bits since load are kept in a queue; a hit is
   // the last len bits equalling the pattern (oldest = pattern[len-1]) with
   // at least len bits seen since load or since the last non-overlapping hit.
   task automatic model_step(input vec_t t);
      bit hit;
      hit = 0;
      if (t.ld) begin
         q.delete();
         m_since = 0;
         if (t.len >= 2 && t.len <= 8) begin
            m_armed = 1; m_err = 0; m_pat = t.pat; m_len = int'(t.len); m_ovl = t.ovl;
         end else begin
            m_armed = 0; m_err = 1;
         end
      end else if (m_armed && t.v) begin
         q.push_back(t.b);
         if (q.size() > 32) void'(q.pop_front());
         m_since++;
         if (m_since >= m_len) begin
            hit = 1;
            for (int k = 0; k < m_len; k++) begin
               if (q[q.size()-1-k] != m_pat[k]) hit = 0;
            end
         end
         if (hit && !m_ovl) m_since = 0;
      end
      m_match = hit;
      if (t.clr) m_cnt = 0;
      else if (hit && m_cnt < 255) m_cnt++;
   endtask

   task automatic apply(input vec_t t, input bit use_tbl, input string nm);
      bus_a.in_valid    = t.v;
      bus_a.in_bit      = t.b;
      bus_a.cfg_load    = t.ld;
      bus_a.cfg_pattern = t.pat;
      bus_a.cfg_len     = t.len;
      bus_a.cfg_overlap = t.ovl;
      bus_a.cnt_clr     = t.clr;
      model_step(t);
      @(posedge clk);
      #1;
      if (use_tbl) begin
         check({nm, "_match"}, 32'(bus_a.match), 32'(t.em));
         check({nm, "_cnt"},   32'(bus_a.match_cnt), 32'(t.ec));
         check({nm, "_armed"}, 32'(bus_a.armed), 32'(t.ea));
         check({nm, "_err"},   32'(bus_a.cfg_err), 32'(t.ee));
      end else begin
         check({nm, "_match"}, 32'(bus_a.match), 32'(m_match));
         check({nm, "_cnt"},   32'(bus_a.match_cnt), 32'(m_cnt));
         check({nm, "_armed"}, 32'(bus_a.armed), 32'(m_armed));
         check({nm, "_err"},   32'(bus_a.cfg_err), 32'(m_err));
      end
   endtask

   task automatic step_b(input logic v, input logic b, input logic ld, input logic clr,
                         input logic em, input int ec, input logic ea);
      bus_b.in_valid    = v;
      bus_b.in_bit      = b;
      bus_b.cfg_load    = ld;
      bus_b.cfg_pattern = 8'h03;
      bus_b.cfg_len     = 4'd2;
      bus_b.cfg_overlap = 1'b1;
      bus_b.cnt_clr     = clr;
      @(posedge clk);
      #1;
      check("sat_match", 32'(bus_b.match), 32'(em));
      check("sat_cnt",   32'(bus_b.match_cnt), 32'(ec));
      check("sat_armed", 32'(bus_b.armed), 32'(ea));
   endtask

   task automatic idle_b();
      bus_b.in_valid = 1'b0; bus_b.in_bit = 1'b0; bus_b.cfg_load = 1'b0;
      bus_b.cfg_pattern = 8'h00; bus_b.cfg_len = 4'd0; bus_b.cfg_overlap = 1'b0;
      bus_b.cnt_clr = 1'b0;
   endtask

   task automatic check_zero_outputs(input string nm);
      check({nm, "_match"}, 32'(bus_a.match), 32'd0);
      check({nm, "_cnt"},   32'(bus_a.match_cnt), 32'd0);
      check({nm, "_armed"}, 32'(bus_a.armed), 32'd0);
      check({nm, "_err"},   32'(bus_a.cfg_err), 32'd0);
   endtask

   initial begin
      vec_t t;
      bit   gap_bits[7];
      bit   rst_bits[4];
      n_checks = 0;
      n_fail   = 0;
      gap_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      rst_bits = '{1'b1, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0;
      t = mk(0,0,0,8'h00,4'd0,0,0,0,8'd0,0,0);
      bus_a.in_valid = 1'b0; bus_a.in_bit = 1'b0; bus_a.cfg_load = 1'b0;
      bus_a.cfg_pattern = 8'h00; bus_a.cfg_len = 4'd0; bus_a.cfg_overlap = 1'b0;
      bus_a.cnt_clr = 1'b0;
      idle_b();
      model_reset();
      #12;
      check_zero_outputs("reset");
      check("reset_b_cnt", 32'(bus_b.match_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---- directed table (DUT A) ----
      // 1101 with don't-care upper pattern bits, overlap
      tbl.push_back(mk(0,0,1,8'hFD,4'd4,1,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 1,8'd1,1,0));
      tbl.push_back(mk(0,0,0,8'h00,4'd0,0,0, 0,8'd1,1,0));
      // 1011 overlapping: hits after bits 4 and 7
      tbl.push_back(mk(0,0,1,8'h0B,4'd4,1,0, 0,8'd1,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd1,1,0));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd1,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd1,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 1,8'd2,1,0));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd2,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd2,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 1,8'd3,1,0));
      // 1011 non-overlapping: hit after bit 4 only
      tbl.push_back(mk(0,0,1,8'h0B,4'd4,0,0, 0,8'd3,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd3,1,0));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd3,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd3,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 1,8'd4,1,0));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd4,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd4,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd4,1,0));
      tbl.push_back(mk(0,0,0,8'h00,4'd0,0,1, 0,8'd0,1,0));
      // illegal lengths 0 and PAT_W+1
      tbl.push_back(mk(0,0,1,8'h0D,4'd0,1,0, 0,8'd0,0,1));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,0,1));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,0,1));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd0,0,1));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,0,1));
      tbl.push_back(mk(0,0,1,8'h0D,4'd9,1,0, 0,8'd0,0,1));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,0,1));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,0,1));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd0,0,1));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,0,1));
      // legal load with a valid bit in the same cycle: that bit is dropped
      tbl.push_back(mk(1,1,1,8'h0D,4'd4,1,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      // full-length pattern 10100101
      tbl.push_back(mk(0,0,1,8'hA5,4'd8,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,0,0,8'h00,4'd0,0,0, 0,8'd0,1,0));
      tbl.push_back(mk(1,1,0,8'h00,4'd0,0,0, 1,8'd1,1,0));
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], 1'b1, "tbl");
      end

      // ---- 1011 overlap with 3-cycle gaps; load also clears the counter ----
      apply(mk(0,0,1,8'h0B,4'd4,1,1, 0,8'd0,1,0), 1'b1, "gap_load");
      for (int i = 0; i < 7; i++) begin
         apply(mk(1,gap_bits[i],0,8'h00,4'd0,0,0,
                  (i == 3 || i == 6) ? 1'b1 : 1'b0,
                  (i >= 6) ? 8'd2 : ((i >= 3) ? 8'd1 : 8'd0), 1,0), 1'b1, "gap_bit");
         for (int g = 0; g < 3; g++) begin
            apply(mk(0,0,0,8'h00,4'd0,0,0, 0,
                     (i >= 6) ? 8'd2 : ((i >= 3) ? 8'd1 : 8'd0), 1,0), 1'b1, "gap_idle");
         end
      end

      // ---- async reset after 3 of 4 bits of 1101 ----
      apply(mk(0,0,1,8'h0D,4'd4,1,0, 0,8'd2,1,0), 1'b1, "rst_load");
      for (int i = 0; i < 3; i++) begin
         apply(mk(1,rst_bits[i],0,8'h00,4'd0,0,0, 0,8'd2,1,0), 1'b1, "rst_bit");
      end
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("rst_async");
      rst_n = 1'b1;
      model_reset();
      apply(mk(1,1,0,8'h00,4'd0,0,0, 0,8'd0,0,0), 1'b1, "rst_idle_bit");

      // ---- async reset cancels a pulsing match ----
      apply(mk(0,0,1,8'h0D,4'd4,1,0, 0,8'd0,1,0), 1'b1, "cancel_load");
      for (int i = 0; i < 4; i++) begin
         apply(mk(1,rst_bits[i],0,8'h00,4'd0,0,0, (i == 3) ? 1'b1 : 1'b0,
                  (i == 3) ? 8'd1 : 8'd0, 1,0), 1'b1, "cancel_bit");
      end
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("cancel_async");
      rst_n = 1'b1;
      model_reset();

      // ---- saturation on the CNT_W=2 instance ----
      step_b(0,0,1,0, 0,0,1);
      for (int i = 0; i < 8; i++) begin
         step_b(1,1,0,0, (i >= 1) ? 1'b1 : 1'b0, (i >= 3) ? 3 : i, 1);
      end
      step_b(1,1,0,1, 1,0,1);
      step_b(1,1,0,0, 1,1,1);
      idle_b();

      // ---- randomized stimulus against the reference model ----
      apply(mk(0,0,1,8'h0D,4'd3,1,0, 0,8'd0,0,0), 1'b0, "rnd_first");
      for (int n = 0; n < 3000; n++) begin
         int r;
         t = mk(0,0,0,8'h00,4'd0,0,0,0,8'd0,0,0);
         t.ld = ($urandom_range(0, 39) == 0);
         if (t.ld) begin
            r = $urandom_range(0, 9);
            if (r == 0)      t.len = 4'($urandom_range(0, 1));
            else if (r == 1) t.len = 4'($urandom_range(9, 15));
            else if (r >= 8) t.len = 4'($urandom_range(5, 8));
            else             t.len = 4'($urandom_range(2, 4));
            t.pat = 8'($urandom_range(0, 255));
            t.ovl = 1'($urandom_range(0, 1));
         end
         t.v   = ($urandom_range(0, 3) != 0);
         t.b   = 1'($urandom_range(0, 1));
         t.clr = ($urandom_range(0, 63) == 0);
         apply(t, 1'b0, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
